// File: rtl/pipe_cskip_adder.sv
// Two-stage pipelined carry-skip adder/subtractor with valid/ready handshake.
// Define PIPE_CSKIP_SAT_EN to clamp the sum to the signed limits on overflow.
module pipe_cskip_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;

    // One half-width adder built from BLOCK-bit ripple blocks; a block whose bits
    // all propagate forwards its carry-in directly instead of the rippled carry.
    function automatic logic [HALF:0] cskipAdd(input logic [HALF-1:0] x,
                                               input logic [HALF-1:0] y,
                                               input logic            ci);
        logic [HALF-1:0] s;
        logic            blkCarry;
        logic            rippleCarry;
        logic            allProp;
        logic            p;
        int              idx;
        s        = '0;
        blkCarry = ci;
        for (int blk = 0; blk < HALF / BLOCK; blk++) begin
            rippleCarry = blkCarry;
            allProp     = 1'b1;
            for (int k = 0; k < BLOCK; k++) begin
                idx         = blk * BLOCK + k;
                p           = x[idx] ^ y[idx];
                s[idx]      = p ^ rippleCarry;
                rippleCarry = (x[idx] & y[idx]) | (p & rippleCarry);
                allProp     = allProp & p;
            end
            blkCarry = allProp ? blkCarry : rippleCarry;
        end
        return {blkCarry, s};
    endfunction

    logic            w_advance;
    logic [WIDTH-1:0] w_bEff;
    logic            w_c0;
    logic [HALF:0]   w_lo;
    logic [HALF:0]   w_hi;
    logic [WIDTH-1:0] w_rawSum;
    logic [WIDTH-1:0] w_finalSum;
    logic            w_ovf;

    logic            r_s1Valid;
    logic [HALF-1:0] r_s1SumLo;
    logic            r_s1CarryLo;
    logic [HALF-1:0] r_s1AHi;
    logic [HALF-1:0] r_s1BHi;
    logic            r_outValid;
    logic [WIDTH-1:0] r_sum;
    logic            r_cout;
    logic            r_ovf;

    assign w_advance = !r_outValid || out_ready;
    assign w_bEff    = sub ? ~b : b;
    assign w_c0      = sub ? ~cin : cin;
    assign w_lo      = cskipAdd(a[HALF-1:0], w_bEff[HALF-1:0], w_c0);
    assign w_hi      = cskipAdd(r_s1AHi, r_s1BHi, r_s1CarryLo);
    assign w_rawSum  = {w_hi[HALF-1:0], r_s1SumLo};
    assign w_ovf     = (r_s1AHi[HALF-1] == r_s1BHi[HALF-1]) &&
                       (w_hi[HALF-1] != r_s1AHi[HALF-1]);

`ifdef PIPE_CSKIP_SAT_EN
    assign w_finalSum = !w_ovf ? w_rawSum :
                        (r_s1AHi[HALF-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign w_finalSum = w_rawSum;
`endif

    // Both stages move together only when the output register can be vacated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s1SumLo   <= '0;
            r_s1CarryLo <= 1'b0;
            r_s1AHi     <= '0;
            r_s1BHi     <= '0;
            r_outValid  <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1SumLo   <= w_lo[HALF-1:0];
                r_s1CarryLo <= w_lo[HALF];
                r_s1AHi     <= a[WIDTH-1:HALF];
                r_s1BHi     <= w_bEff[WIDTH-1:HALF];
            end
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_sum  <= w_finalSum;
                r_cout <= w_hi[HALF];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = r_outValid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_cskip_adder.sv
// Directed and random self-checking bench for pipe_cskip_adder (WIDTH=32, BLOCK=4).
// Saturated-sum expectations follow PIPE_CSKIP_SAT_EN when it is defined.
module tb_pipe_cskip_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    pipe_cskip_adder #(.WIDTH(32), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer reference: plain 33-bit addition of a, effective b and carry-in.
    function automatic res_t refModel(input logic [31:0] x, input logic [31:0] y,
                                      input logic ci, input logic su);
        logic [32:0] t;
        logic [31:0] be;
        logic        c0;
        res_t        r;
        be  = su ? ~y : y;
        c0  = su ? ~ci : ci;
        t   = {1'b0, x} + {1'b0, be} + {32'd0, c0};
        r.s = t[31:0];
        r.c = t[32];
        r.o = (x[31] == be[31]) && (t[31] != x[31]);
`ifdef PIPE_CSKIP_SAT_EN
        if (r.o) r.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

    // Sends one operand set and returns out_valid one cycle later plus the result two cycles later.
    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic opCin, input logic opSub,
                                 output logic earlyValid, output logic lateValid,
                                 output logic [31:0] rSum, output logic rCout, output logic rOvf);
        @(negedge clk);
        a = opA; b = opB; cin = opCin; sub = opSub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        earlyValid = out_valid;
        @(negedge clk);
        lateValid = out_valid;
        rSum      = sum;
        rCout     = cout;
        rOvf      = ovf;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL reset_sum got %h want 00000000", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b want 0", cout); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ignores_in_valid got %b want 0", out_valid); end
    endtask

    task automatic test_skip_chain;
        logic e, l, c, o;
        logic [31:0] s;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e, l, s, c, o);
        checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL skip_early_valid got %b want 0", e); end
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL skip_latency_valid got %b want 1", l); end
        checks++; if (s !== 32'h0000_0000) begin errors++; $display("[TB] FAIL skip_sum got %h want 00000000", s); end
        checks++; if (c !== 1'b1) begin errors++; $display("[TB] FAIL skip_cout got %b want 1", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL skip_ovf got %b want 0", o); end
    endtask

    task automatic test_overflow;
        logic e, l, c, o;
        logic [31:0] s;
        logic [31:0] expSum;
`ifdef PIPE_CSKIP_SAT_EN
        expSum = 32'h7FFF_FFFF;
`else
        expSum = 32'h8000_0000;
`endif
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, e, l, s, c, o);
        checks++; if (l !== 1'b1) begin errors++; $display("[TB] FAIL ovf_valid got %b want 1", l); end
        checks++; if (o !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want 1", o); end
        checks++; if (s !== expSum) begin errors++; $display("[TB] FAIL ovf_sum got %h want %h", s, expSum); end
        checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cout got %b want 0", c); end
        // Negative overflow: 0x80000000 - 1 wraps positive.
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, e, l, s, c, o);
`ifdef PIPE_CSKIP_SAT_EN
        expSum = 32'h8000_0000;
`else
        expSum = 32'h7FFF_FFFF;
`endif
        checks++; if (o !== 1'b1) begin errors++; $display("[TB] FAIL negovf_flag got %b want 1", o); end
        checks++; if (s !== expSum) begin errors++; $display("[TB] FAIL negovf_sum got %h want %h", s, expSum); end
        checks++; if (c !== 1'b1) begin errors++; $display("[TB] FAIL negovf_cout got %b want 1", c); end
    endtask

    task automatic test_subtract;
        logic e, l, c, o;
        logic [31:0] s;
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, e, l, s, c, o);
        checks++; if (s !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL sub_sum got %h want fffffffe", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL sub_cout got %b want 0", c); end
        checks++; if (o !== 1'b0) begin errors++; $display("[TB] FAIL sub_ovf got %b want 0", o); end
        applyStimulus(32'd5, 32'd7, 1'b1, 1'b1, e, l, s, c, o);
        checks++; if (s !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL sub_borrow_sum got %h want fffffffd", s); end
        checks++; if (c !== 1'b0) begin errors++; $display("[TB] FAIL sub_borrow_cout got %b want 0", c); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vA[4], vB[4], eS[4];
        logic        vCin[4], vSub[4], eC[4];
        logic [31:0] heldSum;
        int          tx, rx, stallCnt;
        bit          stalled;
        vA[0] = 32'd1;          vB[0] = 32'd2;          vCin[0] = 0; vSub[0] = 0; eS[0] = 32'd3;        eC[0] = 0;
        vA[1] = 32'h10;         vB[1] = 32'h20;         vCin[1] = 0; vSub[1] = 0; eS[1] = 32'h30;       eC[1] = 0;
        vA[2] = 32'd100;        vB[2] = 32'd1;          vCin[2] = 0; vSub[2] = 1; eS[2] = 32'd99;       eC[2] = 1;
        vA[3] = 32'hF0F0_F0F0;  vB[3] = 32'h0F0F_0F0F;  vCin[3] = 1; vSub[3] = 0; eS[3] = 32'h0;        eC[3] = 1;
        tx = 0; rx = 0; stallCnt = 0; stalled = 0; heldSum = '0;
        for (int cyc = 0; cyc < 40 && rx < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !stalled) begin stalled = 1; stallCnt = 3; heldSum = sum; end
            out_ready = (stallCnt == 0);
            in_valid  = (tx < 4);
            if (tx < 4) begin a = vA[tx]; b = vB[tx]; cin = vCin[tx]; sub = vSub[tx]; end
            #1;
            if (stallCnt > 0) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_stall_in_ready got %b want 0", in_ready); end
                checks++; if (out_valid !== 1'b1 || sum !== heldSum) begin errors++; $display("[TB] FAIL b2b_stall_hold got v=%b %h want v=1 %h", out_valid, sum, heldSum); end
                stallCnt--;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sum !== eS[rx] || cout !== eC[rx] || ovf !== 1'b0) begin
                    errors++; $display("[TB] FAIL b2b_result%0d got %h/%b/%b want %h/%b/0", rx, sum, cout, ovf, eS[rx], eC[rx]);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rx != 4) begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", rx); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_no_dup got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        a = 32'h1234; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        a = 32'h55; b = 32'h0;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("[TB] FAIL midrst_sum got %h want 00000000", sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale cycle %0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_random;
        res_t q[$];
        res_t exp, got;
        int   sent, rcvd;
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 60000 && rcvd < 10000; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = $urandom;
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                got = {sum, cout, ovf};
                if (q.size() == 0) begin
                    errors++; $display("[TB] FAIL rand_unexpected got %h want none", got);
                end else begin
                    exp = q.pop_front();
                    if (got !== exp) begin
                        errors++; $display("[TB] FAIL rand_result%0d got %h want %h", rcvd, got, exp);
                    end
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                q.push_back(refModel(a, b, cin, sub));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (rcvd != 10000) begin errors++; $display("[TB] FAIL rand_count got %0d want 10000", rcvd); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_skip_chain();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
